// File: rtl/sb_port_arbiter.sv
// Round-robin arbiter sharing one hard-IP system-bus port between two requesters.
// One transaction is in flight at a time; a missing ack ends the access with an error.
module sb_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic [7:0] req0_rdata,
    output logic       req0_ready,
    output logic       req0_err,
    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic [7:0] req1_rdata,
    output logic       req1_ready,
    output logic       req1_err,
    output logic       sb_stb,
    output logic       sb_rw,
    output logic [7:0] sb_adr,
    output logic [7:0] sb_dati,
    input  logic [7:0] sb_dato,
    input  logic       sb_ack,
    output logic [7:0] timeout_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sb_stb_q, sb_stb_d;
    logic             sb_rw_q, sb_rw_d;
    logic [7:0]       sb_adr_q, sb_adr_d;
    logic [7:0]       sb_dati_q, sb_dati_d;
    logic [7:0]       req0_rdata_q, req0_rdata_d;
    logic             req0_ready_q, req0_ready_d;
    logic             req0_err_q, req0_err_d;
    logic [7:0]       req1_rdata_q, req1_rdata_d;
    logic             req1_ready_q, req1_ready_d;
    logic             req1_err_q, req1_err_d;
    logic [7:0]       timeout_cnt_q, timeout_cnt_d;
    logic             win;
    logic             finish;
    logic             fail;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        sb_stb_d      = sb_stb_q;
        sb_rw_d       = sb_rw_q;
        sb_adr_d      = sb_adr_q;
        sb_dati_d     = sb_dati_q;
        req0_rdata_d  = req0_rdata_q;
        req0_ready_d  = 1'b0;
        req0_err_d    = req0_err_q;
        req1_rdata_d  = req1_rdata_q;
        req1_ready_d  = 1'b0;
        req1_err_d    = req1_err_q;
        timeout_cnt_d = timeout_cnt_q;
        win           = 1'b0;
        finish        = 1'b0;
        fail          = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // Pointer only matters when both ask; a lone requester always wins.
                    win       = (req0_valid && req1_valid) ? ptr_q : req1_valid;
                    grant_d   = win;
                    sb_rw_d   = win ? req1_write : req0_write;
                    sb_adr_d  = win ? req1_addr  : req0_addr;
                    sb_dati_d = win ? req1_wdata : req0_wdata;
                    sb_stb_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sb_ack) begin
                    finish = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    finish        = 1'b1;
                    fail          = 1'b1;
                    timeout_cnt_d = (timeout_cnt_q == 8'hFF) ? 8'hFF : timeout_cnt_q + 8'd1;
                end
                if (finish) begin
                    sb_stb_d = 1'b0;
                    state_d  = DONE;
                    if (grant_q) begin
                        req1_ready_d = 1'b1;
                        req1_err_d   = fail;
                        if (!sb_rw_q) req1_rdata_d = fail ? 8'hFF : sb_dato;
                    end else begin
                        req0_ready_d = 1'b1;
                        req0_err_d   = fail;
                        if (!sb_rw_q) req0_rdata_d = fail ? 8'hFF : sb_dato;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                ptr_d   = ~grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                sb_stb_d = 1'b0;
            end
        endcase
    end

    // Reset aborts any access in flight without a completion pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            ptr_q         <= 1'b0;
            cnt_q         <= '0;
            sb_stb_q      <= 1'b0;
            sb_rw_q       <= 1'b0;
            sb_adr_q      <= 8'h00;
            sb_dati_q     <= 8'h00;
            req0_rdata_q  <= 8'h00;
            req0_ready_q  <= 1'b0;
            req0_err_q    <= 1'b0;
            req1_rdata_q  <= 8'h00;
            req1_ready_q  <= 1'b0;
            req1_err_q    <= 1'b0;
            timeout_cnt_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            sb_stb_q      <= sb_stb_d;
            sb_rw_q       <= sb_rw_d;
            sb_adr_q      <= sb_adr_d;
            sb_dati_q     <= sb_dati_d;
            req0_rdata_q  <= req0_rdata_d;
            req0_ready_q  <= req0_ready_d;
            req0_err_q    <= req0_err_d;
            req1_rdata_q  <= req1_rdata_d;
            req1_ready_q  <= req1_ready_d;
            req1_err_q    <= req1_err_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign sb_stb      = sb_stb_q;
    assign sb_rw       = sb_rw_q;
    assign sb_adr      = sb_adr_q;
    assign sb_dati     = sb_dati_q;
    assign req0_rdata  = req0_rdata_q;
    assign req0_ready  = req0_ready_q;
    assign req0_err    = req0_err_q;
    assign req1_rdata  = req1_rdata_q;
    assign req1_ready  = req1_ready_q;
    assign req1_err    = req1_err_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_sb_port_arbiter.sv
// Directed bench for sb_port_arbiter built with TIMEOUT=8 so hung accesses end quickly.
// Inputs and observations both happen on the falling clock edge.
module tb_sb_port_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req0_write = 1'b0;
    logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
    logic [7:0] req0_rdata;
    logic       req0_ready, req0_err;
    logic       req1_valid = 1'b0, req1_write = 1'b0;
    logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
    logic [7:0] req1_rdata;
    logic       req1_ready, req1_err;
    logic       sb_stb, sb_rw;
    logic [7:0] sb_adr, sb_dati;
    logic [7:0] sb_dato = 8'h00;
    logic       sb_ack = 1'b0;
    logic [7:0] timeout_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sb_port_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_ready(req0_ready),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_ready(req1_ready),
        .req1_err(req1_err),
        .sb_stb(sb_stb), .sb_rw(sb_rw), .sb_adr(sb_adr), .sb_dati(sb_dati),
        .sb_dato(sb_dato), .sb_ack(sb_ack), .timeout_cnt(timeout_cnt)
    );

    // Runs one transaction from IDLE and reports what was seen; ack_at=0 never acks.
    task automatic run_txn(input logic port, input logic wr, input logic [7:0] addr,
                           input logic [7:0] wdata, input int ack_at, input logic [7:0] dato,
                           output bit done, output int stb_cycles, output logic rdy,
                           output logic err, output logic [7:0] rdata,
                           output logic [7:0] adr_seen, output logic rw_seen,
                           output logic [7:0] dati_seen, output logic other_rdy,
                           output logic rdy_after);
        done = 0; stb_cycles = 0; rdy = 0; err = 0; rdata = 8'h00;
        adr_seen = 8'h00; rw_seen = 0; dati_seen = 8'h00; other_rdy = 0; rdy_after = 1;
        if (port == 1'b0) begin
            req0_valid = 1; req0_write = wr; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = 1; req1_write = wr; req1_addr = addr; req1_wdata = wdata;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (port ? req0_ready : req1_ready) other_rdy = 1;
            if (sb_stb) begin
                stb_cycles++;
                adr_seen = sb_adr; rw_seen = sb_rw; dati_seen = sb_dati;
                if (stb_cycles == ack_at) begin
                    sb_ack = 1; sb_dato = dato;
                end else begin
                    sb_ack = 0;
                end
            end else if (stb_cycles > 0) begin
                sb_ack = 0;
                rdy   = port ? req1_ready : req0_ready;
                err   = port ? req1_err   : req0_err;
                rdata = port ? req1_rdata : req0_rdata;
                done  = 1;
            end
        end
        req0_valid = 0; req1_valid = 0; sb_ack = 0;
        @(negedge clock);
        rdy_after = port ? req1_ready : req0_ready;
    endtask

    task automatic test_reset();
        #12;
        @(negedge clock);
        checks++;
        if ({sb_stb, sb_rw, sb_adr, sb_dati} !== 18'h0) begin
            errors++; $display("[TB] FAIL reset_bus: got %h required 0", {sb_stb, sb_rw, sb_adr, sb_dati});
        end
        checks++;
        if ({req0_ready, req0_err, req0_rdata, req1_ready, req1_err, req1_rdata} !== 20'h0) begin
            errors++; $display("[TB] FAIL reset_req: got %h required 0",
                               {req0_ready, req0_err, req0_rdata, req1_ready, req1_err, req1_rdata});
        end
        checks++;
        if (timeout_cnt !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_tcnt: got %h required 00", timeout_cnt);
        end
        reset = 1;
        sb_ack = 1;
        repeat (2) @(negedge clock);
        checks++;
        if ({sb_stb, req0_ready, req1_ready} !== 3'b000) begin
            errors++; $display("[TB] FAIL idle_ack_ignored: got %b required 000", {sb_stb, req0_ready, req1_ready});
        end
        sb_ack = 0;
    endtask

    task automatic test_single_read();
        bit done; int n; logic rdy, err, rw, oth, aft; logic [7:0] rd, adr, dati;
        run_txn(1'b0, 1'b0, 8'h0C, 8'h00, 3, 8'h5A, done, n, rdy, err, rd, adr, rw, dati, oth, aft);
        checks++;
        if (!done || n != 3) begin
            errors++; $display("[TB] FAIL read_stb_len: got %0d (done=%0d) required 3", n, done);
        end
        checks++;
        if ({adr, rw} !== {8'h0C, 1'b0}) begin
            errors++; $display("[TB] FAIL read_bus: got adr=%h rw=%b required adr=0c rw=0", adr, rw);
        end
        checks++;
        if ({rdy, err, rd} !== {1'b1, 1'b0, 8'h5A}) begin
            errors++; $display("[TB] FAIL read_result: got rdy=%b err=%b rdata=%h required 1 0 5a", rdy, err, rd);
        end
        checks++;
        if ({oth, aft} !== 2'b00) begin
            errors++; $display("[TB] FAIL read_pulse: got other=%b after=%b required 0 0", oth, aft);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_adr;
        logic       exp_port;
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        req0_valid = 1; req0_write = 0; req0_addr = 8'h10;
        req1_valid = 1; req1_write = 0; req1_addr = 8'h20;
        sb_dato = 8'h77;
        reset = 1;
        for (int g = 0; g < 4; g++) begin
            exp_port = (g % 2 == 1);
            exp_adr  = exp_port ? 8'h20 : 8'h10;
            @(negedge clock);
            checks++;
            if ({sb_stb, sb_adr} !== {1'b1, exp_adr}) begin
                errors++; $display("[TB] FAIL grant%0d: got stb=%b adr=%h required 1 %h", g, sb_stb, sb_adr, exp_adr);
            end
            sb_ack = 1;
            @(negedge clock);
            sb_ack = 0;
            checks++;
            if ({sb_stb, req0_ready, req1_ready} !== {1'b0, !exp_port, exp_port}) begin
                errors++; $display("[TB] FAIL ready%0d: got %b required %b", g,
                                   {sb_stb, req0_ready, req1_ready}, {1'b0, !exp_port, exp_port});
            end
            if (g == 3) begin
                req0_valid = 0; req1_valid = 0;
            end
            @(negedge clock);
            checks++;
            if ({sb_stb, req0_ready, req1_ready} !== 3'b000) begin
                errors++; $display("[TB] FAIL gap%0d: got %b required 000", g, {sb_stb, req0_ready, req1_ready});
            end
        end
        checks++;
        if ({req0_rdata, req1_rdata} !== 16'h7777) begin
            errors++; $display("[TB] FAIL contention_rdata: got %h required 7777", {req0_rdata, req1_rdata});
        end
    endtask

    task automatic test_timeout();
        bit done; int n; logic rdy, err, rw, oth, aft; logic [7:0] rd, adr, dati;
        checks++;
        if (timeout_cnt !== 8'h00) begin
            errors++; $display("[TB] FAIL tcnt_start: got %h required 00", timeout_cnt);
        end
        run_txn(1'b1, 1'b0, 8'h33, 8'h00, 0, 8'h00, done, n, rdy, err, rd, adr, rw, dati, oth, aft);
        checks++;
        if (!done || n != 8) begin
            errors++; $display("[TB] FAIL timeout_stb_len: got %0d (done=%0d) required 8", n, done);
        end
        checks++;
        if ({rdy, err, rd, aft} !== {1'b1, 1'b1, 8'hFF, 1'b0}) begin
            errors++; $display("[TB] FAIL timeout_result: got rdy=%b err=%b rdata=%h after=%b required 1 1 ff 0",
                               rdy, err, rd, aft);
        end
        checks++;
        if (timeout_cnt !== 8'h01) begin
            errors++; $display("[TB] FAIL timeout_tcnt: got %h required 01", timeout_cnt);
        end
        run_txn(1'b1, 1'b0, 8'h34, 8'h00, 1, 8'h42, done, n, rdy, err, rd, adr, rw, dati, oth, aft);
        checks++;
        if ({done, rdy, err, rd, timeout_cnt} !== {1'b1, 1'b1, 1'b0, 8'h42, 8'h01}) begin
            errors++; $display("[TB] FAIL after_timeout: got done=%b rdy=%b err=%b rdata=%h tcnt=%h required 1 1 0 42 01",
                               done, rdy, err, rd, timeout_cnt);
        end
    endtask

    task automatic test_ack_at_expiry();
        bit done; int n; logic rdy, err, rw, oth, aft; logic [7:0] rd, adr, dati;
        run_txn(1'b0, 1'b0, 8'h40, 8'h00, 8, 8'h9C, done, n, rdy, err, rd, adr, rw, dati, oth, aft);
        checks++;
        if (!done || n != 8) begin
            errors++; $display("[TB] FAIL expiry_stb_len: got %0d (done=%0d) required 8", n, done);
        end
        checks++;
        if ({rdy, err, rd, timeout_cnt} !== {1'b1, 1'b0, 8'h9C, 8'h01}) begin
            errors++; $display("[TB] FAIL expiry_result: got rdy=%b err=%b rdata=%h tcnt=%h required 1 0 9c 01",
                               rdy, err, rd, timeout_cnt);
        end
    endtask

    task automatic test_write_path();
        bit done; int n; logic rdy, err, rw, oth, aft; logic [7:0] rd, adr, dati;
        logic [7:0] exp_cnt;
        run_txn(1'b0, 1'b1, 8'h1F, 8'hA5, 2, 8'hEE, done, n, rdy, err, rd, adr, rw, dati, oth, aft);
        checks++;
        if ({adr, rw, dati} !== {8'h1F, 1'b1, 8'hA5}) begin
            errors++; $display("[TB] FAIL write_bus: got adr=%h rw=%b dati=%h required 1f 1 a5", adr, rw, dati);
        end
        checks++;
        if ({done, rdy, err, req0_rdata} !== {1'b1, 1'b1, 1'b0, 8'h9C}) begin
            errors++; $display("[TB] FAIL write_result: got done=%b rdy=%b err=%b rdata=%h required 1 1 0 9c",
                               done, rdy, err, req0_rdata);
        end
        run_txn(1'b0, 1'b1, 8'h1F, 8'h11, 0, 8'h00, done, n, rdy, err, rd, adr, rw, dati, oth, aft);
        checks++;
        if ({done, rdy, err, req0_rdata, timeout_cnt} !== {1'b1, 1'b1, 1'b1, 8'h9C, 8'h02}) begin
            errors++; $display("[TB] FAIL write_timeout: got done=%b rdy=%b err=%b rdata=%h tcnt=%h required 1 1 1 9c 02",
                               done, rdy, err, req0_rdata, timeout_cnt);
        end
        exp_cnt = 8'h02;
        for (int i = 0; i < 300; i++) begin
            run_txn(i[0], 1'b0, 8'h50, 8'h00, 0, 8'h00, done, n, rdy, err, rd, adr, rw, dati, oth, aft);
            exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
            checks++;
            if ({done, rdy, err} !== 3'b111) begin
                errors++; $display("[TB] FAIL sat_txn%0d: got %b required 111", i, {done, rdy, err});
            end
            if (i == 100) begin
                checks++;
                if (timeout_cnt !== exp_cnt) begin
                    errors++; $display("[TB] FAIL tcnt_mid: got %h required %h", timeout_cnt, exp_cnt);
                end
            end
        end
        checks++;
        if (timeout_cnt !== 8'hFF) begin
            errors++; $display("[TB] FAIL tcnt_sat: got %h required ff", timeout_cnt);
        end
    endtask

    task automatic test_reset_mid_op();
        int  n = 0;
        logic seen_rdy = 0;
        req0_valid = 1; req0_write = 0; req0_addr = 8'h55;
        for (int i = 0; i < 10 && n < 2; i++) begin
            @(negedge clock);
            if (sb_stb) n++;
        end
        checks++;
        if (n != 2) begin
            errors++; $display("[TB] FAIL midop_reach: got %0d strobe cycles required 2", n);
        end
        reset = 0;
        #1;
        checks++;
        if ({sb_stb, req0_ready, req1_ready, timeout_cnt} !== 11'h0) begin
            errors++; $display("[TB] FAIL midop_async: got stb=%b r0=%b r1=%b tcnt=%h required 0 0 0 00",
                               sb_stb, req0_ready, req1_ready, timeout_cnt);
        end
        req0_valid = 0;
        repeat (3) begin
            @(negedge clock);
            if (req0_ready || req1_ready) seen_rdy = 1;
        end
        req0_valid = 1; req0_addr = 8'h55;
        req1_valid = 1; req1_addr = 8'h66; req1_write = 0;
        reset = 1;
        @(negedge clock);
        if (req0_ready || req1_ready) seen_rdy = 1;
        checks++;
        if (seen_rdy !== 1'b0) begin
            errors++; $display("[TB] FAIL midop_no_ready: got %b required 0", seen_rdy);
        end
        checks++;
        if ({sb_stb, sb_adr} !== {1'b1, 8'h55}) begin
            errors++; $display("[TB] FAIL midop_regrant: got stb=%b adr=%h required 1 55", sb_stb, sb_adr);
        end
        sb_ack = 1;
        @(negedge clock);
        sb_ack = 0;
        req0_valid = 0; req1_valid = 0;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("[TB] FAIL midop_complete: got %b required 10", {req0_ready, req1_ready});
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_timeout();
        test_ack_at_expiry();
        test_write_path();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
